// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared types and helpers for the sequential divider.
//   state_t          FSM encoding (FIXUP only reachable in the signed build)
//   DEFAULT_WIDTH    default operand/result width
//   step_cnt_width() width of the per-bit step counter
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DONE  = 2'd2,
        FIXUP = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must hold 0..width-1; never narrower than one bit.
    function automatic int step_cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/addsub_n.sv
// addsub_n: N-bit carry-look-ahead adder/subtractor.
//   src1, src2  operands
//   sub_flag    1 = src1 - src2 (src2 inverted, carry_in = 1), 0 = src1 + src2
//   sum         N-bit result
//   carry_out   carry out of the MSB; when subtracting, 1 means no borrow
module addsub_n
    import seq_div_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH + 1
) (
    input  logic [N-1:0] src1,
    input  logic [N-1:0] src2,
    input  logic         sub_flag,
    output logic [N-1:0] sum,
    output logic         carry_out
);

    logic [N-1:0] b_eff;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;

    assign c[0] = sub_flag;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign b_eff[gi] = src2[gi] ^ sub_flag;
            assign g[gi]     = src1[gi] & b_eff[gi];
            assign p[gi]     = src1[gi] ^ b_eff[gi];
            assign sum[gi]   = p[gi] ^ c[gi];
        end

        // Each carry is a flat sum of products of g/p and carry_in, so no
        // carry depends on another carry.
        for (genvar gi = 0; gi < N; gi++) begin : g_carry
            logic [gi+1:0] term;
            assign term[gi+1] = sub_flag & (&p[gi:0]);
            for (genvar gk = 0; gk <= gi; gk++) begin : g_term
                if (gk == gi) begin : g_own
                    assign term[gk] = g[gk];
                end else begin : g_prop
                    assign term[gk] = g[gk] & (&p[gi:gk+1]);
                end
            end
            assign c[gi+1] = |term;
        end
    endgenerate

    assign carry_out = c[N];

endmodule

// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider, one quotient bit per clock.
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      request handshake, src1 = dividend, src2 = divisor
//   out_valid/out_ready    result handshake
//   quotient, remainder    registered results, meaningful while out_valid=1
//   div_by_zero            src2 was zero for the presented result
// Build option: define SEQ_DIV_SIGNED_EN for two's-complement operands
// (magnitude division followed by a FIXUP sign-correction state).
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CW   = step_cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] dvd_reg;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dsr_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quot_out_reg, rem_out_reg;
    logic             dbz_reg;

    logic             accept, last_step, no_borrow;
    logic [WIDTH:0]   partial, trial;
    logic [WIDTH-1:0] rem_step, quot_step;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             unused_trial_msb;

`ifdef SEQ_DIV_SIGNED_EN
    logic             neg_q_reg, neg_r_reg;
    assign a_mag = src1[WIDTH-1] ? (~src1 + 1'b1) : src1;
    assign b_mag = src2[WIDTH-1] ? (~src2 + 1'b1) : src2;
`else
    assign a_mag = src1;
    assign b_mag = src2;
`endif

    assign accept    = in_valid & in_ready;
    assign last_step = (cnt_reg == LAST);

    // One restoring step: try partial - divisor, keep it if nothing borrowed.
    assign partial = {rem_reg, dvd_reg[WIDTH-1]};

    addsub_n #(.N(WIDTH + 1)) u_sub (
        .src1      (partial),
        .src2      ({1'b0, dsr_reg}),
        .sub_flag  (1'b1),
        .sum       (trial),
        .carry_out (no_borrow)
    );

    // trial < divisor whenever it is kept, so its MSB is always zero then.
    assign unused_trial_msb = trial[WIDTH];
    assign rem_step  = no_borrow ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
    assign quot_step = {dvd_reg[WIDTH-2:0], no_borrow};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (src2 == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
`ifdef SEQ_DIV_SIGNED_EN
                    state_next = FIXUP;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef SEQ_DIV_SIGNED_EN
            FIXUP: state_next = DONE;
`endif
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode, straight from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            dvd_reg      <= '0;
            dsr_reg      <= '0;
            rem_reg      <= '0;
            quot_out_reg <= '0;
            rem_out_reg  <= '0;
            dbz_reg      <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        dvd_reg <= a_mag;
                        dsr_reg <= b_mag;
                        rem_reg <= '0;
                        cnt_reg <= '0;
`ifdef SEQ_DIV_SIGNED_EN
                        neg_q_reg <= src1[WIDTH-1] ^ src2[WIDTH-1];
                        neg_r_reg <= src1[WIDTH-1];
`endif
                        if (src2 == '0) begin
                            quot_out_reg <= '1;
                            rem_out_reg  <= src1;
                            dbz_reg      <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem_reg <= rem_step;
                    dvd_reg <= quot_step;
                    cnt_reg <= cnt_reg + 1'b1;
`ifndef SEQ_DIV_SIGNED_EN
                    if (last_step) begin
                        quot_out_reg <= quot_step;
                        rem_out_reg  <= rem_step;
                        dbz_reg      <= 1'b0;
                    end
`endif
                end
`ifdef SEQ_DIV_SIGNED_EN
                // Magnitude of most-negative / -1 is already the right bit
                // pattern, so no special case is needed here.
                FIXUP: begin
                    quot_out_reg <= neg_q_reg ? (~dvd_reg + 1'b1) : dvd_reg;
                    rem_out_reg  <= neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
                    dbz_reg      <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    assign quotient    = quot_out_reg;
    assign remainder   = rem_out_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;

    localparam int W = 8;
`ifdef SEQ_DIV_SIGNED_EN
    localparam int EXTRA = 1;
    localparam logic [W-1:0] Q_200_3 = 8'hEE;   // -56 / 3 = -18
    localparam logic [W-1:0] R_200_3 = 8'hFE;   // -56 % 3 = -2
`else
    localparam int EXTRA = 0;
    localparam logic [W-1:0] Q_200_3 = 8'd66;
    localparam logic [W-1:0] R_200_3 = 8'd2;
`endif

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    seq_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src1        (src1),
        .src2        (src2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the definition of division.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t m;
        if (b == '0) begin
            m.q = '1; m.r = a; m.dbz = 1'b1;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
                m.q = a; m.r = '0;
            end else begin
                m.q = W'($signed(a) / $signed(b));
                m.r = W'($signed(a) % $signed(b));
            end
`else
            m.q = a / b;
            m.r = a % b;
`endif
            m.dbz = 1'b0;
        end
        return m;
    endfunction

    function automatic int exp_latency(input logic [W-1:0] b);
        return (b == '0) ? 1 : W + 1 + EXTRA;
    endfunction

    // Compare process: every presented result against the model queue.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("model_quotient",  32'(quotient),    32'(exp_q[0].q));
                check("model_remainder", 32'(remainder),   32'(exp_q[0].r));
                check("model_dbz",       32'(div_by_zero), 32'(exp_q[0].dbz));
                check("in_ready_busy",   32'(in_ready),    32'd0);
                if (out_ready) begin
                    $display("txn: q=%0h r=%0h dbz=%0b", quotient, remainder, div_by_zero);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // One request/response; optional literal expectations and backpressure.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                          input logic chk_lit, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic edbz);
        int           w;
        int           lat;
        logic [W-1:0] q0, r0;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        src1 = a; src2 = b; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk);
        exp_q.push_back(model(a, b));
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", 32'(lat), 32'(exp_latency(b)));
        if (chk_lit) begin
            check("lit_quotient",  32'(quotient),    32'(eq));
            check("lit_remainder", 32'(remainder),   32'(er));
            check("lit_dbz",       32'(div_by_zero), 32'(edbz));
        end
        q0 = quotient; r0 = remainder;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready",  32'(in_ready),  32'd0);
            check("hold_quotient",  32'(quotient),  32'(q0));
            check("hold_remainder", 32'(remainder), 32'(r0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("consume_out_valid", 32'(out_valid), 32'd0);
        check("consume_in_ready",  32'(in_ready),  32'd1);
    endtask

    logic [W-1:0] va [8] = '{8'd37, 8'd128, 8'd254, 8'd17, 8'd99, 8'd1, 8'd64, 8'd250};
    logic [W-1:0] vb [8] = '{8'd5, 8'd128, 8'd3, 8'd255, 8'd10, 8'd2, 8'd0, 8'd16};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; src1 = '0; src2 = '0;
        @(posedge clk); #1;
        check("reset_in_ready",  32'(in_ready),    32'd1);
        check("reset_out_valid", 32'(out_valid),   32'd0);
        check("reset_quotient",  32'(quotient),    32'd0);
        check("reset_remainder", 32'(remainder),   32'd0);
        check("reset_dbz",       32'(div_by_zero), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_op(8'd100, 8'd7,   0, 1'b1, 8'd14,  8'd2, 1'b0);
        run_op(8'd5,   8'd0,   0, 1'b1, 8'hFF,  8'd5, 1'b1);
        run_op(8'd255, 8'd1,   0, 1'b1, 8'hFF,  8'd0, 1'b0);
        run_op(8'd3,   8'd200, 0, 1'b1, 8'd0,   8'd3, 1'b0);
        run_op(8'd0,   8'd9,   0, 1'b1, 8'd0,   8'd0, 1'b0);
        run_op(8'd100, 8'd7,   5, 1'b1, 8'd14,  8'd2, 1'b0);

        // Reset during the 4th CALC cycle discards the operation.
        src1 = 8'd100; src2 = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(8'd100, 8'd7));
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        check("midreset_in_ready",  32'(in_ready),  32'd1);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            check("no_result_after_reset", 32'(out_valid), 32'd0);
        end
        run_op(8'd200, 8'd3, 0, 1'b1, Q_200_3, R_200_3, 1'b0);

`ifdef SEQ_DIV_SIGNED_EN
        run_op(8'h9C, 8'd7,  0, 1'b1, 8'hF2, 8'hFE, 1'b0);
        run_op(8'h80, 8'hFF, 0, 1'b1, 8'h80, 8'h00, 1'b0);
`endif

        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], i % 3, 1'b0, '0, '0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
